// File: rtl/shift_add_multiplier.sv
// Sequential shift/add two's-complement multiplier (WIDTH x WIDTH -> 2*WIDTH) with control FSM.
// Define MULT_UNSIGNED_MODE_EN to build an unsigned multiplier instead of the default signed one.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             X_out,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: Run is a level request sampled in IDLE; Done holds until Run is seen low,
  // so a held Run never launches a second multiply.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  a_reg, b_reg, m_reg;
  logic              x_reg;
  logic [CW-1:0]     count;
  logic [WIDTH:0]    sum;

`ifdef MULT_UNSIGNED_MODE_EN
  always_comb begin
    sum = {1'b0, a_reg} + {1'b0, m_reg};
  end
`else
  logic [WIDTH:0] m_ext, addend;

  // The final multiplier bit carries negative weight, so the last step subtracts.
  always_comb begin
    m_ext  = {m_reg[WIDTH-1], m_reg};
    addend = (count == LAST) ? (~m_ext + {{WIDTH{1'b0}}, 1'b1}) : m_ext;
    sum    = {a_reg[WIDTH-1], a_reg} + addend;
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!ClearA_LoadB && Run) next_state = ST_CLEAR;
      ST_CLEAR: next_state = ST_ADD;
      ST_ADD:   next_state = ST_SHIFT;
      ST_SHIFT: next_state = (count == LAST) ? ST_DONE : ST_ADD;
      ST_DONE:  if (!Run) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      x_reg <= 1'b0;
      count <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (ClearA_LoadB) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= S;
          end else if (Run) begin
            m_reg <= S;
          end
        end
        // B is left alone so the previous low product can serve as the next multiplier.
        ST_CLEAR: begin
          a_reg <= '0;
          x_reg <= 1'b0;
          count <= '0;
        end
        ST_ADD: begin
          if (b_reg[0]) {x_reg, a_reg} <= sum;
        end
        ST_SHIFT: begin
`ifdef MULT_UNSIGNED_MODE_EN
          x_reg <= 1'b0;
`endif
          a_reg <= {x_reg, a_reg[WIDTH-1:1]};
          b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign A_out     = a_reg;
  assign B_out     = b_reg;
  assign X_out     = x_reg;
  assign Busy      = (state == ST_CLEAR) || (state == ST_ADD) || (state == ST_SHIFT);
  assign Done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed vectors plus randomized operands
// checked against an arithmetic product model.
module tb_shift_add_multiplier;
  localparam int W = 8;
  localparam int LATENCY = 2 * W + 1;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         ClearA_LoadB = 1'b0;
  logic         Run = 1'b0;
  logic [W-1:0] S = '0;
  logic [W-1:0] A_out, B_out;
  logic         X_out, Busy, Done;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] model_b = '0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .S(S),
    .A_out(A_out), .B_out(B_out), .X_out(X_out), .Busy(Busy), .Done(Done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] ref_product(input logic [W-1:0] b, input logic [W-1:0] m);
    int bi, mi, p;
`ifdef MULT_UNSIGNED_MODE_EN
    bi = int'(b);
    mi = int'(m);
    p  = bi * mi;
    return {1'b0, p[2*W-1:0]};
`else
    bi = int'($signed(b));
    mi = int'($signed(m));
    p  = bi * mi;
    return {p[2*W-1], p[2*W-1:0]};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_b(input logic [W-1:0] v);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    S = v;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    model_b = v;
  endtask

  // Starts a multiply, scrambles S after acceptance, waits (bounded) for Done.
  task automatic run_mult(input logic [W-1:0] m, output logic [2*W:0] obs, output int lat);
    @(negedge Clk);
    Run = 1'b1;
    S = m;
    @(negedge Clk);
    S = '1;
    lat = 0;
    while (!Done && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    obs = {X_out, A_out, B_out};
  endtask

  task automatic release_run();
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [2*W:0] obs;
    int lat;
    repeat (2) @(negedge Clk);
    total++;
    if ({X_out, A_out, B_out, Busy, Done} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {X_out, A_out, B_out, Busy, Done});
    end
    Reset = 1'b0;
    load_b(8'h5A);
    @(negedge Clk);
    Run = 1'b1;
    S = 8'h33;
    repeat (3) @(negedge Clk);   // accept, CLEAR, ADD -> now in SHIFT
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_mid_op got=%b exp=1", Busy);
    end
    Reset = 1'b1;
    @(negedge Clk);
    total++;
    if ({X_out, A_out, B_out} !== '0) begin
      bad++;
      $display("FAIL reset_mid_shift_data got=%h exp=0", {X_out, A_out, B_out});
    end
    total++;
    if ({Busy, Done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_shift_flags got=%b exp=00", {Busy, Done});
    end
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL run_held_through_reset got=%b exp=1", Busy);
    end
    lat = 0;
    while (!Done && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    total++;
    if ({Done, X_out, A_out, B_out} !== {1'b1, {(2*W+1){1'b0}}}) begin
      bad++;
      $display("FAIL post_reset_product got=%h exp=%h", {Done, X_out, A_out, B_out}, {1'b1, {(2*W+1){1'b0}}});
    end
    release_run();
    model_b = '0;
  endtask

  task automatic test_spec_vectors();
    logic [W-1:0] bs[4], ms[4];
    logic [2*W:0] lits[4];
    logic [2*W:0] obs, exp_v;
    int lat;
`ifdef MULT_UNSIGNED_MODE_EN
    bs = '{8'hFF, 8'h02, 8'h10, 8'h00};
    ms = '{8'hFF, 8'h80, 8'h10, 8'hAB};
    lits = '{17'h0_FE01, 17'h0_0100, 17'h0_0100, 17'h0_0000};
`else
    bs = '{8'hC5, 8'hFE, 8'h80, 8'h7F};
    ms = '{8'h07, 8'hFD, 8'h80, 8'h80};
    lits = '{17'h1_FE63, 17'h0_0006, 17'h0_4000, 17'h1_C080};
`endif
    for (int i = 0; i < 4; i++) begin
      load_b(bs[i]);
      exp_q.push_back(ref_product(bs[i], ms[i]));
      run_mult(ms[i], obs, lat);
      exp_v = exp_q.pop_front();
      total++;
      if (lat !== LATENCY) begin
        bad++;
        $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, LATENCY);
      end
      total++;
      if (obs !== exp_v || obs !== lits[i]) begin
        bad++;
        $display("FAIL vector_%0d got=%h exp=%h", i, obs, lits[i]);
      end
      release_run();
      model_b = obs[W-1:0];
    end
  endtask

  task automatic test_chain();
    logic [2*W:0] obs, exp_v;
    int lat;
    load_b(8'hC5);
    run_mult(8'h07, obs, lat);
    release_run();
    model_b = obs[W-1:0];
    exp_q.push_back(ref_product(model_b, 8'h02));
    run_mult(8'h02, obs, lat);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL chain_product got=%h exp=%h", obs, exp_v);
    end
    repeat (4) @(negedge Clk);
    total++;
    if ({Done, Busy, X_out, A_out, B_out} !== {2'b10, exp_v}) begin
      bad++;
      $display("FAIL run_held_in_done got=%h exp=%h", {Done, Busy, X_out, A_out, B_out}, {2'b10, exp_v});
    end
    release_run();
    total++;
    if ({Done, Busy} !== 2'b00) begin
      bad++;
      $display("FAIL back_to_idle got=%b exp=00", {Done, Busy});
    end
    model_b = exp_v[W-1:0];
  endtask

  task automatic test_load_priority();
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Run = 1'b1;
    S = 8'h3C;
    @(negedge Clk);
    total++;
    if ({Busy, X_out, A_out, B_out} !== {2'b00, 8'h00, 8'h3C}) begin
      bad++;
      $display("FAIL load_priority got=%h exp=%h", {Busy, X_out, A_out, B_out}, {2'b00, 8'h00, 8'h3C});
    end
    ClearA_LoadB = 1'b0;
    Run = 1'b0;
    @(negedge Clk);
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL load_no_start got=%b exp=0", Busy);
    end
    model_b = 8'h3C;
  endtask

  task automatic test_clear_during_busy();
    logic [2*W:0] exp_v;
    int lat;
    exp_v = ref_product(model_b, 8'h5B);
    @(negedge Clk);
    Run = 1'b1;
    S = 8'h5B;
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    S = 8'h11;
    lat = 0;
    while (!Done && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    @(negedge Clk);
    total++;
    if ({Done, X_out, A_out, B_out} !== {1'b1, exp_v}) begin
      bad++;
      $display("FAIL clear_ignored_busy got=%h exp=%h", {Done, X_out, A_out, B_out}, {1'b1, exp_v});
    end
    ClearA_LoadB = 1'b0;
    release_run();
    model_b = exp_v[W-1:0];
  endtask

  task automatic test_random();
    logic [W-1:0] corners[5];
    logic [W-1:0] m;
    logic [2*W:0] obs, exp_v;
    int lat;
    corners = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) == 0) load_b(corners[$urandom_range(0, 4)]);
        else load_b(W'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) m = corners[$urandom_range(0, 4)];
      else m = W'($urandom_range(0, 255));
      exp_q.push_back(ref_product(model_b, m));
      run_mult(m, obs, lat);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v || lat !== LATENCY) begin
        bad++;
        $display("FAIL random_%0d b=%h m=%h got=%h lat=%0d exp=%h lat=%0d", i, model_b, m, obs, lat, exp_v, LATENCY);
      end
      release_run();
      model_b = exp_v[W-1:0];
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_spec_vectors();
    test_chain();
    test_load_priority();
    test_clear_during_busy();
    test_random();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
